// File: rtl/dnn_seq_ctl_pkg.sv
// Shared types and sizes for the matrix-vector sequencer.
package dnn_ctl_pkg;

  localparam int unsigned AW_DEF = 13;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned LAT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    DRAIN,
    OUT,
    DONE
  } ctl_state_t;

endpackage

// File: rtl/dnn_seq_ctl_if.sv
// Host command and buffer strobe bundle of the sequencer.
// The master side is the sequencer; the slave side is the host/buffers.
interface dnn_seq_ctl_if
  import dnn_ctl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
);

  logic             run;
  logic             abort;
  logic [CNT_W-1:0] vs_m1;
  logic [CNT_W-1:0] um_m1;
  logic             exec;
  logic [AW-1:0]    ia;
  logic             init;
  logic             outr;
  logic [AW-1:0]    oa;
  logic             busy;
  logic             done;
  logic             bank;

  modport master (
    input  run, abort, vs_m1, um_m1,
    output exec, ia, init, outr, oa, busy, done, bank
  );

  modport slave (
    output run, abort, vs_m1, um_m1,
    input  exec, ia, init, outr, oa, busy, done, bank
  );

endinterface

// File: rtl/dnn_seq_ctl.sv
// Sequencer turning a run command into source reads and destination write strobes.
// Optional build macro DNN_PINGPONG_EN: toggle bank on every completed run.
module dnn_seq_ctl
  import dnn_ctl_pkg::*;
#(
  parameter int unsigned LAT = 4,
  parameter int unsigned AW  = AW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  dnn_seq_ctl_if.master  bus
);

  ctl_state_t       state;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] j;
  logic [CNT_W-1:0] vs;
  logic [CNT_W-1:0] um;
  logic [LAT_W-1:0] d;
  logic             bank;

  assign bus.bank = bank;

  function automatic logic [AW-1:0] mk_addr(input logic b, input logic [CNT_W-1:0] c);
    mk_addr            = '0;
    mk_addr[AW-1]      = b;
    mk_addr[CNT_W-1:0] = c;
  endfunction

  // Outputs are loaded with the values of the state being entered, so every
  // strobe is registered and lines up with its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      j        <= '0;
      vs       <= '0;
      um       <= '0;
      d        <= '0;
      bank     <= 1'b0;
      bus.exec <= 1'b0;
      bus.init <= 1'b0;
      bus.outr <= 1'b0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
      bus.ia   <= '0;
      bus.oa   <= '0;
    end else if (bus.abort && state != IDLE) begin
      state    <= IDLE;
      bus.exec <= 1'b0;
      bus.init <= 1'b0;
      bus.outr <= 1'b0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.exec <= 1'b0;
      bus.init <= 1'b0;
      bus.outr <= 1'b0;
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.run && !bus.abort) begin
            state    <= EXEC;
            vs       <= bus.vs_m1;
            um       <= bus.um_m1;
            k        <= '0;
            j        <= '0;
            bus.exec <= 1'b1;
            bus.init <= 1'b1;
            bus.ia   <= mk_addr(bank, '0);
            bus.busy <= 1'b1;
          end
        end
        EXEC: begin
          if (k == vs) begin
            state <= DRAIN;
            d     <= LAT_W'(LAT - 1);
          end else begin
            k        <= k + CNT_W'(1);
            bus.exec <= 1'b1;
            bus.ia   <= mk_addr(bank, k + CNT_W'(1));
          end
        end
        DRAIN: begin
          if (d == '0) begin
            state    <= OUT;
            bus.outr <= 1'b1;
            bus.oa   <= mk_addr(bank, j);
          end else begin
            d <= d - LAT_W'(1);
          end
        end
        OUT: begin
          if (j == um) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            state    <= EXEC;
            j        <= j + CNT_W'(1);
            k        <= '0;
            bus.exec <= 1'b1;
            bus.init <= 1'b1;
            bus.ia   <= mk_addr(bank, '0);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
`ifdef DNN_PINGPONG_EN
          bank     <= ~bank;
`else
          bank     <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_seq_ctl.sv
// Randomized bench for dnn_seq_ctl against a per-cycle expected-trace model.
module tb_dnn_seq_ctl;
  import dnn_ctl_pkg::*;

  localparam int unsigned LAT = 4;

  typedef struct packed {
    logic        exec;
    logic [12:0] ia;
    logic        init;
    logic        outr;
    logic [12:0] oa;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dnn_seq_ctl_if #(.AW(13)) bus ();

  dnn_seq_ctl #(.LAT(LAT), .AW(13)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t q[$];
  logic mbank = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_busy   = 0;
  int   n_outr   = 0;
  int   n_done   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected cycle-by-cycle trace of one accepted run.
  task automatic push_run(input logic [11:0] vs, input logic [11:0] um);
    exp_t e;
    for (int unsigned j = 0; j <= um; j++) begin
      for (int unsigned k = 0; k <= vs; k++) begin
        e = '0; e.exec = 1'b1; e.ia = {mbank, 12'(k)}; e.init = (k == 0);
        q.push_back(e);
      end
      for (int unsigned t = 0; t < LAT; t++) begin
        e = '0;
        q.push_back(e);
      end
      e = '0; e.outr = 1'b1; e.oa = {mbank, 12'(j)};
      q.push_back(e);
    end
    e = '0; e.done = 1'b1;
    q.push_back(e);
  endtask

  // One clock: compare current outputs, then drive the next inputs and advance the model.
  task automatic cyc(input logic r, input logic a, input logic rs,
                     input logic [11:0] vs, input logic [11:0] um);
    exp_t e;
    logic act;
    @(negedge clk);
    act = (q.size() != 0);
    e   = '0;
    if (act) e = q.pop_front();
    check_eq("busy", bus.busy, act);
    check_eq("exec", bus.exec, e.exec);
    check_eq("init", bus.init, e.init);
    check_eq("outr", bus.outr, e.outr);
    check_eq("done", bus.done, e.done);
    check_eq("bank", bus.bank, mbank);
    check_eq("exec_outr_excl", bus.exec & bus.outr, 0);
    if (e.exec) check_eq("ia", bus.ia, e.ia);
    if (e.outr) check_eq("oa", bus.oa, e.oa);
    n_busy += int'(bus.busy);
    n_outr += int'(bus.outr);
    n_done += int'(bus.done);
    reset     = rs;
    bus.run   = r;
    bus.abort = a;
    bus.vs_m1 = vs;
    bus.um_m1 = um;
    if (rs) begin
      q.delete();
      mbank = 1'b0;
    end else if (act) begin
      if (a) q.delete();
`ifdef DNN_PINGPONG_EN
      else if (e.done) mbank = ~mbank;
`endif
    end else if (r && !a) begin
      push_run(vs, um);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      cyc(1'b0, 1'b0, 1'b0, 12'($urandom), 12'($urandom));
      n++;
    end
    check_eq("wait_timeout", q.size(), 0);
    idle(1);
  endtask

  task automatic full_run(input logic [11:0] vs, input logic [11:0] um);
    n_busy = 0; n_outr = 0; n_done = 0;
    cyc(1'b1, 1'b0, 1'b0, vs, um);
    wait_idle(int'(um + 1) * (int'(vs) + LAT + 2) + 16);
    check_eq("busy_cycles", n_busy, (int'(um) + 1) * (int'(vs) + 1 + LAT + 1) + 1);
    check_eq("outr_count", n_outr, int'(um) + 1);
    check_eq("done_count", n_done, 1);
  endtask

  initial begin
    reset = 1'b1; bus.run = 1'b0; bus.abort = 1'b0; bus.vs_m1 = '0; bus.um_m1 = '0;
    repeat (2) @(posedge clk);
    cyc(1'b0, 1'b0, 1'b1, 12'd0, 12'd0);
    check_eq("ia_rst", bus.ia, 0);
    check_eq("oa_rst", bus.oa, 0);
    idle(2);

    full_run(12'd3, 12'd1);
    full_run(12'd0, 12'd0);
    full_run(12'd4095, 12'd0);

    // abort on the third exec cycle
    n_outr = 0; n_done = 0;
    cyc(1'b1, 1'b0, 1'b0, 12'd5, 12'd2);
    idle(2);
    cyc(1'b0, 1'b1, 1'b0, 12'd5, 12'd2);
    idle(3);
    check_eq("abort_outr", n_outr, 0);
    check_eq("abort_done", n_done, 0);
    full_run(12'd2, 12'd1);

    // abort and run together in idle
    cyc(1'b1, 1'b1, 1'b0, 12'd3, 12'd3);
    idle(2);

    // run and new sizes while busy are ignored
    n_outr = 0;
    cyc(1'b1, 1'b0, 1'b0, 12'd2, 12'd2);
    idle(5);
    cyc(1'b1, 1'b0, 1'b0, 12'd7, 12'd7);
    wait_idle(200);
    check_eq("busy_run_outr", n_outr, 3);

    // back-to-back runs, then reset in the middle of a third
    full_run(12'd1, 12'd1);
    full_run(12'd2, 12'd0);
    full_run(12'd1, 12'd0);
    cyc(1'b1, 1'b0, 1'b0, 12'd3, 12'd1);
    idle(4);
    cyc(1'b0, 1'b0, 1'b1, 12'd0, 12'd0);
    cyc(1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
    check_eq("ia_after_rst", bus.ia, 0);
    check_eq("bank_after_rst", bus.bank, 0);
    idle(2);

    // random traffic with stray runs, aborts and resets
    for (int it = 0; it < 40; it++) begin
      logic [11:0] vs, um;
      int n;
      vs = 12'($urandom_range(0, 6));
      um = 12'($urandom_range(0, 3));
      cyc(1'b1, 1'b0, 1'b0, vs, um);
      n = 0;
      while (q.size() != 0 && n < 200) begin
        cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 199) == 0), 12'($urandom), 12'($urandom));
        n++;
      end
      check_eq("rand_timeout", q.size(), 0);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dnn_seq_ctl.md
# dnn_seq_ctl

Sequencer for the matrix-vector engine. It turns a single `run` command into the `exec`/`ia` read stream for the source buffer and the `outr`/`oa` write-back strobes for the destination buffer. It sits between the host register interface and the src/dst buffers plus MAC datapath. It owns bank selection (address bit 12) and the accumulator-clear (`init`) timing.

## Interface
Parameters:
- `LAT`, 4: cycles from the last `exec` cycle until the accumulated result `x` is valid at the destination buffer (includes the 1-cycle source read); legal range 1..15.
- `AW`, 13: buffer address width; bit `AW-1` is the bank bit.

Ports:
- `clk` in 1: clock. One clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `run` in 1: start pulse; sampled only in IDLE.
- `abort` in 1: synchronous cancel.
- `vs_m1` in 12: inputs per output minus 1 (1..4096 inputs).
- `um_m1` in 12: number of outputs minus 1 (1..4096 outputs).
- `exec` out 1: source-buffer read enable.
- `ia` out 13: source address, `{bank, k[11:0]}`.
- `init` out 1: clear accumulator; coincides with the first `exec` of each output.
- `outr` out 1: destination write strobe.
- `oa` out 13: destination address, `{bank, j[11:0]}`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on completion.
- `bank` out 1: bank currently owned by the engine.

## Operation
- States:
  - IDLE → EXEC on `run`. Latch `vs_m1`/`um_m1`, clear `k=0`, `j=0`.
  - EXEC: `exec=1`, `ia={bank,k}`, `init=(k==0)`. When `k==vs_m1` go to DRAIN (load `d=LAT-1`); otherwise `k++`.
  - DRAIN: `d--`; when `d==0` go to OUT.
  - OUT: `outr=1`, `oa={bank,j}`. If `j==um_m1` go to DONE; else `j++`, `k=0`, go to EXEC.
  - DONE: `done=1` for one cycle, then IDLE; toggle `bank` (see Configuration).
- All outputs are registered. Reset values: `exec=0`, `init=0`, `outr=0`, `ia=0`, `oa=0`, `busy=0`, `done=0`, `bank=0`, state IDLE.
- Counters `k`, `j` are 12-bit. Compare with equality only, so there is no wrap. `vs_m1=4095` yields exactly 4096 exec cycles.
- `run` while `busy` is ignored, with no queuing.
- `abort` in any non-IDLE state: the next cycle is IDLE with all strobes low. No `outr`, no `done`, and `bank` is not toggled. A partial output is never written.
- If `abort` and `run` arrive in the same cycle in IDLE, `abort` wins and the engine stays IDLE.
- `reset` mid-operation has the same effect as `abort`, and additionally sets `bank=0`.
- `vs_m1`/`um_m1` may change while `busy` without effect, because latched copies are used.

## Timing
- `run` high at cycle 0 → first `exec`/`init` at cycle 1.
- Per output: `vs_m1+1` EXEC cycles, then `LAT` DRAIN cycles, then 1 OUT cycle.
- Total busy cycles: `(um_m1+1)*(vs_m1+1+LAT+1) + 1` (the final +1 is DONE).
- `outr` appears exactly `LAT+1` cycles after the last `exec` of that output.
- `busy` rises the cycle after `run` and falls the cycle after `done`.
- `exec` and `outr` are never high together.

## Configuration
- `DNN_PINGPONG_EN` defined: `bank` toggles on every DONE. The host may fill source bank `~bank` and drain destination bank `~bank` while the engine runs.
- `DNN_PINGPONG_EN` undefined: `bank` is tied to 0, and `ia[12]`/`oa[12]` are always 0. The single-bank host flow must wait for `done`.

## Structure
- Package `dnn_ctl_pkg` holds:
  - state enum `ctl_state_t` (IDLE, EXEC, DRAIN, OUT, DONE);
  - `AW_DEF=13`, `CNT_W=12`, `LAT_W=4`.
- A single module: counters and FSM are inline, with no sub-module.

## Test plan
- Basic: `vs_m1=3`, `um_m1=1`, `LAT=4`, `run` at cycle 0. Expect `exec` at cycles 1–4 with `ia=0..3` and `init` at cycle 1, `outr` at cycle 9 with `oa=0`, `exec` at cycles 10–13, `outr` at cycle 18 with `oa=1`, `done` at cycle 19.
- Max size: `vs_m1=4095`, `um_m1=0`. Expect 4096 exec cycles with `ia` running 0..4095 and no wrap, then `outr` `oa=0` `LAT+1` cycles after the last `exec`.
- Abort: `abort` during the third EXEC cycle. Expect `exec=0` the next cycle, no `outr`, no `done`, `bank` unchanged, and a following `run` working normally.
- Ping-pong (`DNN_PINGPONG_EN`): two back-to-back runs. Expect the first run to use `ia[12]=oa[12]=0` and the second to use 1; `bank` is 1 after the first `done` and 0 after the second.
- Busy run ignored: a `run` pulse mid-operation produces no extra outputs, and the total `outr` count equals `um_m1+1`.
- Reset mid-run with `bank=1`: all outputs return to 0 on the next cycle and `bank=0`.
